// File: rtl/disp_scan_ctrl.sv
// Four-digit seven-segment scan controller: one digit per slot, blanked anodes during the
// slot guard time, per-digit blink, hour leading-zero blanking and a blinking colon.
module disp_scan_ctrl #(
  parameter int SCAN_DIV  = 100000,
  parameter int GUARD     = 16,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] time_Bcd,
  input  logic [3:0]  digit_Blink,
  input  logic        disp_En,
  input  logic        lead_Zero_Blank,
  output logic [3:0]  bcd_Out,
  output logic        disp_On,
  output logic [3:0]  an_Out,
  output logic        dp_Out
);

  localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [SW-1:0] slot_cnt;
  logic [1:0]    dig_idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  logic       slot_end, blink_end, guard, vis;
  logic [3:0] nib, an_nxt;

  assign slot_end  = (slot_cnt == SW'(SCAN_DIV - 1));
  assign blink_end = (blink_cnt == BW'(BLINK_DIV - 1));
  assign guard     = (slot_cnt < SW'(GUARD));
  assign nib       = time_Bcd[{dig_idx, 2'b00} +: 4];

  assign vis = disp_En && !guard
            && !(digit_Blink[dig_idx] && !blink_phase)
            && !(dig_idx == 2'd3 && lead_Zero_Blank && time_Bcd[15:12] == 4'h0);

  // Blanked digits keep their anode driven; only the decoder enable darkens them.
  for (genvar i = 0; i < 4; i++) begin : g_an
    assign an_nxt[i] = guard || !disp_En || (dig_idx != 2'(i));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt    <= '0;
      dig_idx     <= 2'd0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
      bcd_Out     <= 4'h0;
      disp_On     <= 1'b0;
      an_Out      <= 4'b1111;
      dp_Out      <= 1'b1;
    end else begin
      slot_cnt  <= slot_end ? '0 : slot_cnt + 1'b1;
      if (slot_end) dig_idx <= dig_idx + 2'd1;
      blink_cnt <= blink_end ? '0 : blink_cnt + 1'b1;
      if (blink_end) blink_phase <= !blink_phase;
      bcd_Out   <= nib;
      disp_On   <= vis;
      an_Out    <= an_nxt;
      dp_Out    <= !(dig_idx == 2'd2 && vis && blink_phase);
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed-vector bench for disp_scan_ctrl at SCAN_DIV=8, GUARD=2, BLINK_DIV=64.
// Vector k = number of rising edges since reset release; output at k reflects state at edge k.
module tb_disp_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] time_Bcd = 16'h1234;
  logic [3:0]  digit_Blink = 4'h0;
  logic        disp_En = 1'b1;
  logic        lead_Zero_Blank = 1'b0;
  logic [3:0]  bcd_Out;
  logic        disp_On;
  logic [3:0]  an_Out;
  logic        dp_Out;

  disp_scan_ctrl #(.SCAN_DIV(8), .GUARD(2), .BLINK_DIV(64)) dut (
    .clk(clk), .reset(reset), .time_Bcd(time_Bcd), .digit_Blink(digit_Blink),
    .disp_En(disp_En), .lead_Zero_Blank(lead_Zero_Blank),
    .bcd_Out(bcd_Out), .disp_On(disp_On), .an_Out(an_Out), .dp_Out(dp_Out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        restart;
    int          k;
    logic [15:0] tb;
    logic [3:0]  bl;
    logic        en;
    logic        lzb;
    logic [3:0]  bcd;
    logic        on;
    logic [3:0]  an;
    logic        dp;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cur = 0;

  task automatic check(input string name, input logic [3:0] bcd, input logic on,
                       input logic [3:0] an, input logic dp);
    n_chk++;
    if ({bcd_Out, disp_On, an_Out, dp_Out} === {bcd, on, an, dp}) n_pass++;
    else $display("FAIL %s: got bcd=%h on=%b an=%b dp=%b, want bcd=%h on=%b an=%b dp=%b",
                  name, bcd_Out, disp_On, an_Out, dp_Out, bcd, on, an, dp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cur++;
  endtask

  task automatic set_in(input vec_t v);
    time_Bcd = v.tb; digit_Blink = v.bl; disp_En = v.en; lead_Zero_Blank = v.lzb;
  endtask

  task automatic do_reset(input vec_t v);
    reset = 1'b1;
    set_in(v);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    cur = 0;
  endtask

  initial begin
    // scan order, colon, blink-phase boundary
    vecs.push_back('{1'b1,   1, 16'h1234, 4'h0, 1'b1, 1'b0, 4'h4, 1'b0, 4'hF, 1'b1});
    vecs.push_back('{1'b0,   2, 16'h1234, 4'h0, 1'b1, 1'b0, 4'h4, 1'b0, 4'hF, 1'b1});
    vecs.push_back('{1'b0,   3, 16'h1234, 4'h0, 1'b1, 1'b0, 4'h4, 1'b1, 4'hE, 1'b1});
    vecs.push_back('{1'b0,   8, 16'h1234, 4'h0, 1'b1, 1'b0, 4'h4, 1'b1, 4'hE, 1'b1});
    vecs.push_back('{1'b0,   9, 16'h1234, 4'h0, 1'b1, 1'b0, 4'h3, 1'b0, 4'hF, 1'b1});
    vecs.push_back('{1'b0,  11, 16'h1234, 4'h0, 1'b1, 1'b0, 4'h3, 1'b1, 4'hD, 1'b1});
    vecs.push_back('{1'b0,  17, 16'h1234, 4'h0, 1'b1, 1'b0, 4'h2, 1'b0, 4'hF, 1'b1});
    vecs.push_back('{1'b0,  19, 16'h1234, 4'h0, 1'b1, 1'b0, 4'h2, 1'b1, 4'hB, 1'b0});
    vecs.push_back('{1'b0,  24, 16'h1234, 4'h0, 1'b1, 1'b0, 4'h2, 1'b1, 4'hB, 1'b0});
    vecs.push_back('{1'b0,  25, 16'h1234, 4'h0, 1'b1, 1'b0, 4'h1, 1'b0, 4'hF, 1'b1});
    vecs.push_back('{1'b0,  27, 16'h1234, 4'h0, 1'b1, 1'b0, 4'h1, 1'b1, 4'h7, 1'b1});
    vecs.push_back('{1'b0,  33, 16'h1234, 4'h0, 1'b1, 1'b0, 4'h4, 1'b0, 4'hF, 1'b1});
    vecs.push_back('{1'b0,  35, 16'h1234, 4'h0, 1'b1, 1'b0, 4'h4, 1'b1, 4'hE, 1'b1});
    vecs.push_back('{1'b0,  64, 16'h1234, 4'h0, 1'b1, 1'b0, 4'h1, 1'b1, 4'h7, 1'b1});
    vecs.push_back('{1'b0,  65, 16'h1234, 4'h0, 1'b1, 1'b0, 4'h4, 1'b0, 4'hF, 1'b1});
    vecs.push_back('{1'b0,  83, 16'h1234, 4'h0, 1'b1, 1'b0, 4'h2, 1'b1, 4'hB, 1'b1});
    vecs.push_back('{1'b0, 147, 16'h1234, 4'h0, 1'b1, 1'b0, 4'h2, 1'b1, 4'hB, 1'b0});
    // blink on digits 0 and 1
    vecs.push_back('{1'b1,   3, 16'h1234, 4'h3, 1'b1, 1'b0, 4'h4, 1'b1, 4'hE, 1'b1});
    vecs.push_back('{1'b0,  11, 16'h1234, 4'h3, 1'b1, 1'b0, 4'h3, 1'b1, 4'hD, 1'b1});
    vecs.push_back('{1'b0,  19, 16'h1234, 4'h3, 1'b1, 1'b0, 4'h2, 1'b1, 4'hB, 1'b0});
    vecs.push_back('{1'b0,  67, 16'h1234, 4'h3, 1'b1, 1'b0, 4'h4, 1'b0, 4'hE, 1'b1});
    vecs.push_back('{1'b0,  75, 16'h1234, 4'h3, 1'b1, 1'b0, 4'h3, 1'b0, 4'hD, 1'b1});
    vecs.push_back('{1'b0,  83, 16'h1234, 4'h3, 1'b1, 1'b0, 4'h2, 1'b1, 4'hB, 1'b1});
    vecs.push_back('{1'b0,  91, 16'h1234, 4'h3, 1'b1, 1'b0, 4'h1, 1'b1, 4'h7, 1'b1});
    vecs.push_back('{1'b0, 131, 16'h1234, 4'h3, 1'b1, 1'b0, 4'h4, 1'b1, 4'hE, 1'b1});
    vecs.push_back('{1'b0, 139, 16'h1234, 4'h3, 1'b1, 1'b0, 4'h3, 1'b1, 4'hD, 1'b1});
    // leading-zero blanking
    vecs.push_back('{1'b1,   3, 16'h0905, 4'h0, 1'b1, 1'b1, 4'h5, 1'b1, 4'hE, 1'b1});
    vecs.push_back('{1'b0,  11, 16'h0905, 4'h0, 1'b1, 1'b1, 4'h0, 1'b1, 4'hD, 1'b1});
    vecs.push_back('{1'b0,  19, 16'h0905, 4'h0, 1'b1, 1'b1, 4'h9, 1'b1, 4'hB, 1'b0});
    vecs.push_back('{1'b0,  27, 16'h0905, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 4'h7, 1'b1});
    vecs.push_back('{1'b1,  27, 16'h0905, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 4'h7, 1'b1});
    // nibbles above 9 pass through; nonzero hr_tens never zero-blanked
    vecs.push_back('{1'b1,   3, 16'hCDEF, 4'h0, 1'b1, 1'b1, 4'hF, 1'b1, 4'hE, 1'b1});
    vecs.push_back('{1'b0,  11, 16'hCDEF, 4'h0, 1'b1, 1'b1, 4'hE, 1'b1, 4'hD, 1'b1});
    vecs.push_back('{1'b0,  19, 16'hCDEF, 4'h0, 1'b1, 1'b1, 4'hD, 1'b1, 4'hB, 1'b0});
    vecs.push_back('{1'b0,  27, 16'hCDEF, 4'h0, 1'b1, 1'b1, 4'hC, 1'b1, 4'h7, 1'b1});
    // display disabled, then re-enabled mid-run
    vecs.push_back('{1'b1,   3, 16'h1234, 4'h0, 1'b0, 1'b0, 4'h4, 1'b0, 4'hF, 1'b1});
    vecs.push_back('{1'b0,  19, 16'h1234, 4'h0, 1'b0, 1'b0, 4'h2, 1'b0, 4'hF, 1'b1});
    vecs.push_back('{1'b0,  27, 16'h1234, 4'h0, 1'b0, 1'b0, 4'h1, 1'b0, 4'hF, 1'b1});
    vecs.push_back('{1'b0,  35, 16'h1234, 4'h0, 1'b1, 1'b0, 4'h4, 1'b1, 4'hE, 1'b1});

    // reset held 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", 4'h0, 1'b0, 4'hF, 1'b1);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].restart) do_reset(vecs[i]);
      else set_in(vecs[i]);
      while (cur < vecs[i].k) step();
      check($sformatf("vec%0d_k%0d", i, vecs[i].k), vecs[i].bcd, vecs[i].on, vecs[i].an, vecs[i].dp);
    end

    // one-cycle reset at slot 5 of digit 2
    do_reset(vecs[0]);
    while (cur < 21) step();
    check("pre_reset_dig2", 4'h2, 1'b1, 4'hB, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midslot_reset", 4'h0, 1'b0, 4'hF, 1'b1);
    reset = 1'b0;
    cur = 0;
    step(); check("restart_guard0", 4'h4, 1'b0, 4'hF, 1'b1);
    step(); check("restart_guard1", 4'h4, 1'b0, 4'hF, 1'b1);
    step(); check("restart_dig0",   4'h4, 1'b1, 4'hE, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
